// File: rtl/expu_sched.sv
// Control sequencer for expu_top: meters a job into N_ROWS-wide beats and
// tracks in-flight beats through the enable-gated pipeline to a valid/ready output.
module expu_sched #(
    parameter int unsigned N_ROWS    = 1,
    parameter int unsigned NUM_REGS  = 0,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 expu_en_o,
    output logic [N_ROWS-1:0]    expu_strb_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N_ROWS-1:0]    out_strb_o,
    output logic                 out_last_o
);

    localparam int unsigned CW = LEN_WIDTH + 1;
    localparam logic [CW-1:0] ROWS_C = CW'(N_ROWS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 advance;
    logic                 accept;
    logic                 rem_nz;
    logic                 tail;
    logic [N_ROWS-1:0]    strb0;
    logic                 last0;

    assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign rem_nz     = (rem_q != '0);
    assign tail       = ({1'b0, rem_q} <= ROWS_C);
    assign in_ready_o = (state_q == ST_RUN) && advance && rem_nz && !clear_i;
    assign accept     = in_ready_o && in_valid_i;
    assign expu_en_o  = busy_o && advance && !clear_i;
    assign last0      = accept && tail;

    // Lanes 0..min(N_ROWS,rem)-1 are live on an accepted beat.
    always_comb begin
        strb0 = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            strb0[i] = accept && ({1'b0, rem_q} > CW'(i));
        end
    end
    assign expu_strb_o = strb0;

    if (NUM_REGS == 0) begin : g_comb
        // No storage: a beat can only be accepted when the sink takes it.
        assign advance     = out_ready_i;
        assign out_valid_o = accept;
        assign out_strb_o  = strb0;
        assign out_last_o  = last0;
    end else begin : g_pipe
        // Index i holds pipeline entry i+1.
        logic [NUM_REGS-1:0] vld_q;
        logic [NUM_REGS-1:0] last_q;
        logic [N_ROWS-1:0]   strb_q [NUM_REGS];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q  <= '0;
                last_q <= '0;
                for (int unsigned i = 0; i < NUM_REGS; i++) strb_q[i] <= '0;
            end else if (clear_i) begin
                vld_q  <= '0;
                last_q <= '0;
                for (int unsigned i = 0; i < NUM_REGS; i++) strb_q[i] <= '0;
            end else if (expu_en_o) begin
                vld_q[0]  <= accept;
                last_q[0] <= last0;
                strb_q[0] <= strb0;
                for (int unsigned i = 1; i < NUM_REGS; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    last_q[i] <= last_q[i-1];
                    strb_q[i] <= strb_q[i-1];
                end
            end
        end

        assign out_valid_o = vld_q[NUM_REGS-1];
        assign out_strb_o  = strb_q[NUM_REGS-1];
        assign out_last_o  = last_q[NUM_REGS-1];
        assign advance     = !(out_valid_o && !out_ready_i);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = ST_RUN;
                        rem_d   = len_i;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rem_d = tail ? '0 : rem_q - LEN_WIDTH'(N_ROWS);
                    if (tail) state_d = (NUM_REGS == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_o && out_ready_i && out_last_o) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

endmodule
